mem_port_arbiter: RTL and testbench

Shares a single-ported unified instruction/data memory between the IF stage (instruction reads) and the MEM stage (data loads/stores). It sequences one memory transaction at a time and registers the returned data. It raises hold signals so the pipeline stalls while a requester is waiting. Priority goes to MEM, which holds the older instruction, and a bounded starvation counter guarantees IF forward progress.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-ported instruction/data memory between the IF stage
// (instruction reads) and the MEM stage (loads and stores). It runs one
// memory transaction at a time and registers the returned data.
//
// MEM normally wins a tie because it holds the older instruction. A
// saturating starvation counter tracks MEM wins made while IF was also
// waiting. Once that counter reaches STARVE_LIMIT, IF wins the next tie.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   if_req / if_addr    : IF read request, held until if_done
//   if_rdata / if_done  : registered instruction word and one-cycle done pulse
//   mem_req / mem_we /
//   mem_addr / mem_wdata: MEM load/store request, held until mem_done
//   mem_rdata / mem_done: registered load data and one-cycle done pulse
//   ram_req / ram_we /
//   ram_addr / ram_wdata: registered memory access strobe and controls
//   ram_rdata / ram_ready: memory read data, and the strobe that completes
//                          the current access
//   hold_pc / hold_if   : freeze the PC and the IF/ID register while IF waits
//   hold_mem            : freeze MEM and older stages while MEM waits
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,

    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,

    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ready,

    output logic          hold_pc,
    output logic          hold_if,
    output logic          hold_mem
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state_reg,      state_next;
    logic [3:0]      starve_cnt_reg, starve_cnt_next;
    logic            ram_req_reg,    ram_req_next;
    logic            ram_we_reg,     ram_we_next;
    logic [AW-1:0]   ram_addr_reg,   ram_addr_next;
    logic [DW-1:0]   ram_wdata_reg,  ram_wdata_next;
    logic            if_done_reg,    if_done_next;
    logic            mem_done_reg,   mem_done_next;
    logic [DW-1:0]   if_rdata_reg,   if_rdata_next;
    logic [DW-1:0]   mem_rdata_reg,  mem_rdata_next;

    // A requester whose done pulse is high this cycle still holds its request
    // line, but it has already been served. It must not be granted again.
    logic if_elig;
    logic mem_elig;
    logic grant_if;
    logic grant_mem;

    assign if_elig   = if_req  && !if_done_reg;
    assign mem_elig  = mem_req && !mem_done_reg;
    assign grant_if  = if_elig && (!mem_elig || (starve_cnt_reg == LIMIT));
    assign grant_mem = mem_elig && !grant_if;

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        ram_req_next    = ram_req_reg;
        ram_we_next     = ram_we_reg;
        ram_addr_next   = ram_addr_reg;
        ram_wdata_next  = ram_wdata_reg;
        if_done_next    = 1'b0;
        mem_done_next   = 1'b0;
        if_rdata_next   = if_rdata_reg;
        mem_rdata_next  = mem_rdata_reg;

        case (state_reg)
            IDLE: begin
                // ram_ready is deliberately ignored in this state.
                if (grant_if) begin
                    state_next      = IF_BUSY;
                    ram_req_next    = 1'b1;
                    ram_we_next     = 1'b0;
                    ram_addr_next   = if_addr;
                    ram_wdata_next  = '0;
                    starve_cnt_next = '0;
                end else if (grant_mem) begin
                    state_next     = MEM_BUSY;
                    ram_req_next   = 1'b1;
                    ram_we_next    = mem_we;
                    ram_addr_next  = mem_addr;
                    ram_wdata_next = mem_wdata;
                    if (if_elig && (starve_cnt_reg < LIMIT)) begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end
            end

            IF_BUSY: begin
                if (ram_ready) begin
                    state_next    = IDLE;
                    ram_req_next  = 1'b0;
                    ram_we_next   = 1'b0;
                    if_done_next  = 1'b1;
                    if_rdata_next = ram_rdata;
                end
            end

            MEM_BUSY: begin
                if (ram_ready) begin
                    state_next    = IDLE;
                    ram_req_next  = 1'b0;
                    ram_we_next   = 1'b0;
                    mem_done_next = 1'b1;
                    // A store returns no data, so the last load value is kept.
                    if (!ram_we_reg) begin
                        mem_rdata_next = ram_rdata;
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                ram_req_next = 1'b0;
                ram_we_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            ram_req_reg    <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            if_done_reg    <= 1'b0;
            mem_done_reg   <= 1'b0;
            if_rdata_reg   <= '0;
            mem_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            ram_req_reg    <= ram_req_next;
            ram_we_reg     <= ram_we_next;
            ram_addr_reg   <= ram_addr_next;
            ram_wdata_reg  <= ram_wdata_next;
            if_done_reg    <= if_done_next;
            mem_done_reg   <= mem_done_next;
            if_rdata_reg   <= if_rdata_next;
            mem_rdata_reg  <= mem_rdata_next;
        end
    end

    assign ram_req   = ram_req_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign if_done   = if_done_reg;
    assign mem_done  = mem_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;

    // The holds are combinational, so the pipeline stalls in the same cycle a
    // request appears. They drop in the cycle the done pulse is high.
    assign hold_pc  = !rst && if_elig;
    assign hold_if  = !rst && if_elig;
    assign hold_mem = !rst && mem_elig;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Each table row holds the inputs for one
// clock cycle and the outputs expected in that same cycle. The starvation
// corner case is a hand-written loop.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        hold_pc;
    logic        hold_if;
    logic        hold_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .hold_pc   (hold_pc),
        .hold_if   (hold_if),
        .hold_mem  (hold_mem)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        ram_ready;
        logic [31:0] ram_rdata;
        logic        e_ram_req;
        logic        e_ram_we;
        logic [31:0] e_ram_addr;
        logic [31:0] e_ram_wdata;
        logic        e_if_done;
        logic [31:0] e_if_rdata;
        logic        e_mem_done;
        logic [31:0] e_mem_rdata;
        logic        e_hold_pc;
        logic        e_hold_mem;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        rst       = v.rst;
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        mem_req   = v.mem_req;
        mem_we    = v.mem_we;
        mem_addr  = v.mem_addr;
        mem_wdata = v.mem_wdata;
        ram_ready = v.ram_ready;
        ram_rdata = v.ram_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; ram_ready = 0; ram_rdata = 0;
        repeat (2) @(posedge clk);

        // Reset: outputs at reset values, holds forced low during reset.
        vecs.push_back('{1,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0});
        vecs.push_back('{1,1,32'h40,1,0,32'h0,32'h0,1,32'h0,      0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0});
        // Single IF read, ram_ready one cycle after ram_req.
        vecs.push_back('{0,1,32'h40,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h0,32'h0,0,32'h0,0,32'h0,1,0});
        vecs.push_back('{0,1,32'h40,0,0,32'h0,32'h0,0,32'h0,      1,0,32'h40,32'h0,0,32'h0,0,32'h0,1,0});
        vecs.push_back('{0,1,32'h40,0,0,32'h0,32'h0,1,32'h21080001, 1,0,32'h40,32'h0,0,32'h0,0,32'h0,1,0});
        vecs.push_back('{0,1,32'h40,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h40,32'h0,1,32'h21080001,0,32'h0,0,0});
        vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h40,32'h0,0,32'h21080001,0,32'h0,0,0});
        // Simultaneous: MEM load first, IF granted in the mem_done cycle.
        vecs.push_back('{0,1,32'h44,1,0,32'h100,32'h0,0,32'h0,    0,0,32'h40,32'h0,0,32'h21080001,0,32'h0,1,1});
        vecs.push_back('{0,1,32'h44,1,0,32'h100,32'h0,1,32'hDEADBEEF, 1,0,32'h100,32'h0,0,32'h21080001,0,32'h0,1,1});
        vecs.push_back('{0,1,32'h44,1,0,32'h100,32'h0,0,32'h0,    0,0,32'h100,32'h0,0,32'h21080001,1,32'hDEADBEEF,1,0});
        vecs.push_back('{0,1,32'h44,0,0,32'h0,32'h0,1,32'h13,     1,0,32'h44,32'h0,0,32'h21080001,0,32'hDEADBEEF,1,0});
        vecs.push_back('{0,1,32'h44,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h44,32'h0,1,32'h13,0,32'hDEADBEEF,0,0});
        vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h44,32'h0,0,32'h13,0,32'hDEADBEEF,0,0});
        // Store with three wait states; mem_rdata must not take ram_rdata.
        vecs.push_back('{0,0,32'h0,1,1,32'h200,32'h12345678,0,32'h0, 0,0,32'h44,32'h0,0,32'h13,0,32'hDEADBEEF,0,1});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{0,0,32'h0,1,1,32'h200,32'h12345678,0,32'hBAD0BAD0, 1,1,32'h200,32'h12345678,0,32'h13,0,32'hDEADBEEF,0,1});
        vecs.push_back('{0,0,32'h0,1,1,32'h200,32'h12345678,1,32'hBAD0BAD0, 1,1,32'h200,32'h12345678,0,32'h13,0,32'hDEADBEEF,0,1});
        vecs.push_back('{0,0,32'h0,1,1,32'h200,32'h12345678,0,32'h0, 0,0,32'h200,32'h12345678,0,32'h13,1,32'hDEADBEEF,0,0});
        vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h200,32'h12345678,0,32'h13,0,32'hDEADBEEF,0,0});
        // Spurious ready while idle.
        for (int i = 0; i < 2; i++)
            vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,1,32'hFFFFFFFF, 0,0,32'h200,32'h12345678,0,32'h13,0,32'hDEADBEEF,0,0});
        // Reset in the second busy cycle of an IF read, then a fresh read.
        vecs.push_back('{0,1,32'h80,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h200,32'h12345678,0,32'h13,0,32'hDEADBEEF,1,0});
        vecs.push_back('{0,1,32'h80,0,0,32'h0,32'h0,0,32'h0,      1,0,32'h80,32'h0,0,32'h13,0,32'hDEADBEEF,1,0});
        vecs.push_back('{1,1,32'h80,0,0,32'h0,32'h0,1,32'h5555AAAA, 1,0,32'h80,32'h0,0,32'h13,0,32'hDEADBEEF,0,0});
        vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0});
        vecs.push_back('{0,1,32'h84,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h0,32'h0,0,32'h0,0,32'h0,1,0});
        vecs.push_back('{0,1,32'h84,0,0,32'h0,32'h0,1,32'h77,     1,0,32'h84,32'h0,0,32'h0,0,32'h0,1,0});
        vecs.push_back('{0,1,32'h84,0,0,32'h0,32'h0,0,32'h0,      0,0,32'h84,32'h0,1,32'h77,0,32'h0,0,0});
        vecs.push_back('{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,       0,0,32'h84,32'h0,0,32'h77,0,32'h0,0,0});

        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle();
            apply(vecs[i]);
            @(negedge clk);
            chk("ram_req",   i, 32'(ram_req),   32'(vecs[i].e_ram_req));
            chk("ram_we",    i, 32'(ram_we),    32'(vecs[i].e_ram_we));
            chk("ram_addr",  i, ram_addr,       vecs[i].e_ram_addr);
            chk("ram_wdata", i, ram_wdata,      vecs[i].e_ram_wdata);
            chk("if_done",   i, 32'(if_done),   32'(vecs[i].e_if_done));
            chk("if_rdata",  i, if_rdata,       vecs[i].e_if_rdata);
            chk("mem_done",  i, 32'(mem_done),  32'(vecs[i].e_mem_done));
            chk("mem_rdata", i, mem_rdata,      vecs[i].e_mem_rdata);
            chk("hold_pc",   i, 32'(hold_pc),   32'(vecs[i].e_hold_pc));
            chk("hold_if",   i, 32'(hold_if),   32'(vecs[i].e_hold_pc));
            chk("hold_mem",  i, 32'(hold_mem),  32'(vecs[i].e_hold_mem));
            $display("vec %0d: ram_req=%0b addr=%08h if_done=%0b mem_done=%0b hold_pc=%0b hold_mem=%0b",
                     i, ram_req, ram_addr, if_done, mem_done, hold_pc, hold_mem);
        end

        chk("starve_idle", 0, 32'(dut.starve_cnt_reg), 32'd0);

        // Starvation: both request together each round. Both drop in the done
        // cycle, so IF never gets a lone grant. Four MEM wins, then IF wins.
        for (r = 1; r <= 5; r++) begin
            next_cycle();
            rst = 0; if_req = 1; if_addr = 32'h300;
            mem_req = 1; mem_we = 0; mem_addr = 32'h400 + 32'(r * 4); mem_wdata = 0;
            ram_ready = 0; ram_rdata = 0;
            @(negedge clk);
            next_cycle();
            ram_ready = 1; ram_rdata = 32'(r);
            @(negedge clk);
            chk("starve_ram_req", r, 32'(ram_req), 32'd1);
            chk("starve_addr", r, ram_addr, (r <= 4) ? 32'h400 + 32'(r * 4) : 32'h300);
            chk("starve_cnt", r, 32'(dut.starve_cnt_reg), (r <= 4) ? 32'(r) : 32'd0);
            next_cycle();
            if_req = 0; mem_req = 0; ram_ready = 0;
            @(negedge clk);
            if (r <= 4) begin
                chk("starve_mem_done", r, 32'(mem_done), 32'd1);
                chk("starve_if_done",  r, 32'(if_done),  32'd0);
                chk("starve_mem_rdata", r, mem_rdata, 32'(r));
            end else begin
                chk("starve_if_done",  r, 32'(if_done),  32'd1);
                chk("starve_mem_done", r, 32'(mem_done), 32'd0);
                chk("starve_if_rdata", r, if_rdata, 32'd5);
            end
            $display("starve round %0d: addr=%08h if_done=%0b mem_done=%0b cnt=%0d",
                     r, ram_addr, if_done, mem_done, dut.starve_cnt_reg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
